// File: rtl/sprite_mover.sv
// sprite_mover: tile-stepping sprite controller with map lookup, bounds check
// and pixel-by-pixel walk animation.
module sprite_mover #(
  parameter int unsigned TILE_LEN   = 32,
  parameter int unsigned LOG_LEN    = 5,
  parameter int unsigned WALK_DELAY = 5,
  parameter int unsigned MAP_W      = 20,
  parameter int unsigned MAP_H      = 10,
  parameter int unsigned START_R    = 1,
  parameter int unsigned START_C    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  output logic [5:0] query_r,
  output logic [5:0] query_c,
  input  logic       wall_hit,
  output logic [5:0] tile_r,
  output logic [5:0] tile_c,
  output logic [9:0] pos_r,
  output logic [9:0] pos_c,
  output logic [1:0] dir,
  output logic       moving,
  output logic       anim_frame,
  output logic       step_done,
  output logic       blocked
);

  localparam int unsigned TW = 6;
  localparam int unsigned PW = 10;
  localparam logic [1:0] DIR_DOWN  = 2'd0;
  localparam logic [1:0] DIR_UP    = 2'd1;
  localparam logic [1:0] DIR_LEFT  = 2'd2;
  localparam logic [1:0] DIR_RIGHT = 2'd3;
  localparam logic [LOG_LEN-1:0] LAST_OFF = LOG_LEN'(TILE_LEN - 1);

  typedef enum logic [1:0] {IDLE, CHECK, MOVE} state_t;

  state_t                state;
  logic [WALK_DELAY-1:0] sub_cnt;
  logic [LOG_LEN-1:0]    offset;
  logic                  oob;

  logic                  req_any;
  logic [1:0]            req_dir;
  logic [TW-1:0]         tgt_r;
  logic [TW-1:0]         tgt_c;
  logic                  tgt_oob;
  logic [LOG_LEN-1:0]    offset_nx;

  // Button priority decode and target tile / bounds evaluation.
  always_comb begin
    req_any   = btn_up | btn_down | btn_left | btn_right;
    req_dir   = dir;
    tgt_r     = tile_r;
    tgt_c     = tile_c;
    tgt_oob   = 1'b0;
    offset_nx = offset + LOG_LEN'(1);
    if (btn_up) begin
      req_dir = DIR_UP;
      tgt_r   = tile_r - TW'(1);
      tgt_oob = (tile_r == '0);
    end else if (btn_down) begin
      req_dir = DIR_DOWN;
      tgt_r   = tile_r + TW'(1);
      tgt_oob = (32'(tile_r) >= MAP_H - 1);
    end else if (btn_left) begin
      req_dir = DIR_LEFT;
      tgt_c   = tile_c - TW'(1);
      tgt_oob = (tile_c == '0);
    end else if (btn_right) begin
      req_dir = DIR_RIGHT;
      tgt_c   = tile_c + TW'(1);
      tgt_oob = (32'(tile_c) >= MAP_W - 1);
    end
  end

  // Step FSM with registered outputs; pos tracks tile*TILE_LEN +/- offset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      tile_r     <= TW'(START_R);
      tile_c     <= TW'(START_C);
      query_r    <= TW'(START_R);
      query_c    <= TW'(START_C);
      pos_r      <= PW'(START_R * TILE_LEN);
      pos_c      <= PW'(START_C * TILE_LEN);
      offset     <= '0;
      sub_cnt    <= '0;
      oob        <= 1'b0;
      dir        <= DIR_DOWN;
      moving     <= 1'b0;
      anim_frame <= 1'b0;
      step_done  <= 1'b0;
      blocked    <= 1'b0;
    end else begin
      step_done <= 1'b0;
      blocked   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_any) begin
            dir <= req_dir;
            oob <= tgt_oob;
            if (!tgt_oob) begin
              query_r <= tgt_r;
              query_c <= tgt_c;
            end
            state <= CHECK;
          end
        end
        CHECK: begin
          if (wall_hit || oob) begin
            blocked <= 1'b1;
            state   <= IDLE;
          end else begin
            sub_cnt    <= '0;
            offset     <= '0;
            anim_frame <= 1'b0;
            moving     <= 1'b1;
            state      <= MOVE;
          end
        end
        MOVE: begin
          sub_cnt <= sub_cnt + WALK_DELAY'(1);
          if (&sub_cnt) begin
            // one pixel in the facing direction
            case (dir)
              DIR_DOWN:  pos_r <= pos_r + PW'(1);
              DIR_UP:    pos_r <= pos_r - PW'(1);
              DIR_LEFT:  pos_c <= pos_c - PW'(1);
              default:   pos_c <= pos_c + PW'(1);
            endcase
            if (offset == LAST_OFF) begin
              tile_r     <= query_r;
              tile_c     <= query_c;
              offset     <= '0;
              anim_frame <= 1'b0;
              moving     <= 1'b0;
              step_done  <= 1'b1;
              state      <= IDLE;
            end else begin
              offset     <= offset_nx;
              anim_frame <= offset_nx[LOG_LEN-1];
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
